// File: rtl/tl_tx_pkg.sv
// Shared types and TLP header field positions for the TX framer.
// Header parsing only looks at DW0 of the first flit of each TLP.
package tl_tx_pkg;

  localparam int FLIT_W          = 256;
  localparam int HDR_LEN_LSB     = 0;
  localparam int HDR_LEN_MSB     = 9;
  localparam int HDR_HASDATA_BIT = 30;
  localparam int DW_PER_FLIT     = 8;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } tx_state_t;

  // Payload flit count for a DW length field; len==0 encodes 1024 DW.
  function automatic logic [7:0] flit_count(input logic [9:0] len);
    logic [10:0] sum;
    sum = {1'b0, len} + 11'(DW_PER_FLIT - 1);
    return (len == 10'd0) ? 8'd128 : sum[10:3];
  endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// 2-entry valid/ready buffer. Entry 0 is always the head and drives the outputs,
// so the downstream view is fully registered.
module tl_skid_buf #(
  parameter int W = 258
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_q != 2'd0) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    // Push lands in the first free slot after any same-cycle pop.
    if (push_i && cnt_d != 2'd2) begin
      if (cnt_d == 2'd0) e0_d = push_data_i;
      else               e1_d = push_data_i;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o = e0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/tl_tx_framer.sv
// Drains a show-ahead TL FIFO, tags each flit with sop/eop from the header
// length, and presents the flits through a registered skid buffer.
module tl_tx_framer
  import tl_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int MAX_LEN_DW = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_sop_o,
  output logic                  tx_eop_o,
  output logic [CNT_WIDTH-1:0]  tlp_cnt_o,
  output logic                  busy_o,
  output logic                  err_o
);

  tx_state_t            state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH+1:0] head;
  logic                  tag_sop, tag_eop;
  logic [9:0]            len;
  logic [10:0]           len_dw;
  logic                  has_data;
  logic                  tx_pop;

  assign fifo_rden_o = ~rst & ~fifo_empty_i & (buf_cnt != 2'd2);
  assign tx_pop      = tx_valid_o & tx_ready_i;

  assign len      = fifo_rdata_i[HDR_LEN_MSB:HDR_LEN_LSB];
  assign has_data = fifo_rdata_i[HDR_HASDATA_BIT];
  assign len_dw   = (len == 10'd0) ? 11'd1024 : {1'b0, len};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tag_sop = 1'b0;
    tag_eop = 1'b0;
    if (fifo_rden_o) begin
      if (state_q == HDR) begin
        tag_sop = 1'b1;
        if (!has_data) begin
          tag_eop = 1'b1;
        end else begin
          rem_d   = flit_count(len);
          state_d = PAYLOAD;
          if (len_dw > 11'(MAX_LEN_DW)) err_d = 1'b1;
        end
      end else begin
        tag_eop = (rem_q == 8'd1);
        rem_d   = rem_q - 8'd1;
        if (rem_q == 8'd1) state_d = HDR;
      end
    end
    if (tx_pop && tx_eop_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      rem_q   <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  tl_skid_buf #(.W(DATA_WIDTH + 2)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_rden_o),
    .push_data_i({tag_sop, tag_eop, fifo_rdata_i}),
    .pop_i      (tx_pop),
    .head_o     (head),
    .cnt_o      (buf_cnt)
  );

  assign tx_valid_o = (buf_cnt != 2'd0);
  assign tx_sop_o   = head[DATA_WIDTH+1];
  assign tx_eop_o   = head[DATA_WIDTH];
  assign tx_data_o  = head[DATA_WIDTH-1:0];
  assign tlp_cnt_o  = cnt_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q == PAYLOAD) | (buf_cnt != 2'd0);

endmodule
